regfile_scan_checker: RTL and testbench
=======================================

Name: regfile_scan_checker

Overview:
- Synthesizable, parametrised successor to the simulation-only end-of-test register dump.
- Counts a cycle budget while the processor runs, snooping regfile writes.
- Then takes over the regfile read ports and scans every register, LANES registers per cycle, against a synchronous expected-value ROM.
- Reports errors and a mismatch stream. It sits between the processor read-address outputs and the regfile, so both an FPGA self-check build and the bench can use it.

Parameters:
- DATA_WIDTH, 32, register data width
- NUM_REGS, 32, registers scanned; must be a multiple of LANES
- ADDR_WIDTH, 5, register address width; equals clog2(NUM_REGS)
- LANES, 2, read ports hijacked in parallel (1..NUM_REGS)
- CYCLE_WIDTH, 14, width of cycle budget/counter
- DEFAULT_CYCLES, 255, budget used when num_cycles==0
- STOP_ON_FAIL, 0, 1 = end scan at first mismatching group

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  begin a run; sampled in IDLE or DONE only
- num_cycles  input  CYCLE_WIDTH  run budget, sampled with start
- cpu_addr  input  LANES*ADDR_WIDTH  processor read addresses, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rf_read_addr  output  LANES*ADDR_WIDTH  addresses driven to the regfile read ports
- rf_read_data  input  LANES*DATA_WIDTH  combinational regfile read data
- exp_addr  output  ADDR_WIDTH  group index to the expected ROM
- exp_data  input  LANES*DATA_WIDTH  ROM data, valid 1 cycle after exp_addr
- rwe  input  1  snooped regfile write enable
- rd  input  5  snooped write register
- test_mode  output  1  high while the regfile is hijacked
- cycle_count  output  CYCLE_WIDTH  run cycles elapsed
- write_count  output  16  snooped writes with rd!=0, saturating at 16'hFFFF
- mismatch_valid  output  1  one-cycle pulse per failing group
- mismatch_reg  output  ADDR_WIDTH  register number of the lowest failing lane
- mismatch_exp  output  DATA_WIDTH  expected value for that register
- mismatch_act  output  DATA_WIDTH  actual value for that register
- error_count  output  ADDR_WIDTH+1  total mismatching registers
- done  output  1  held high in DONE
- pass  output  1  done && error_count==0

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, all outputs 0, test_mode=0 immediately. rf_read_addr then equals cpu_addr combinationally. The same applies to a reset asserted mid-RUN or mid-SCAN: the pipeline is discarded and nothing partial is reported.
- rf_read_addr lane i = test_mode ? (g*LANES+i) : cpu_addr lane i. g is the issue group register; exp_addr = g.
- IDLE: on start, latch budget B = (num_cycles==0) ? DEFAULT_CYCLES : num_cycles. Clear cycle_count, write_count, error_count and done. Go to RUN.
- RUN: cycle_count increments each cycle. write_count increments when rwe && rd!=0. When cycle_count==B-1 at a clock edge, go to SCAN with g=0 and test_mode=1 from that edge. Exactly B RUN cycles are counted.
- SCAN, issue stage: each cycle present group g and increment g. After group NUM_REGS/LANES-1 is issued, stop issuing.
- SCAN, compare stage: one cycle behind issue. rf_read_data is registered alongside the ROM output so both refer to group g-1. Lane i mismatches when exp != act.
  - error_count += popcount(mismatching lanes).
  - If any lane mismatches, pulse mismatch_valid with the lowest failing lane's register, expected and actual values.
- Write snooping is ignored while test_mode=1.
- Scan length: NUM_REGS/LANES + 1 cycles. Then go to DONE and set test_mode=0.
- STOP_ON_FAIL=1: the first failing compare goes to DONE on the next edge. The in-flight issued group is discarded, so error_count counts only that group's failing lanes.
- DONE: done=1; counters hold. start restarts as from IDLE. start in RUN/SCAN is ignored.
- error_count cannot overflow (max NUM_REGS). Register 0 is compared like any other.

Test Plan:
- Defaults; num_cycles=10; CPU writes r3=7 at cycle 2 and r0=5 at cycle 4; ROM all zero except r3=7 -> test_mode rises after exactly 10 RUN cycles; write_count=1; done after 17 scan cycles; error_count=0; pass=1.
- num_cycles=0 -> 255 RUN cycles counted before test_mode rises.
- ROM r4=1 and r5=2 (same group, LANES=2); regfile holds 0 -> one mismatch_valid pulse with reg=4, exp=1, act=0; error_count=2; pass=0.
- STOP_ON_FAIL=1; mismatches at r6 and r20 -> done two cycles after r6's group is issued; error_count=1; no pulse for r20.
- Assert reset low mid-SCAN at group 5 -> test_mode=0 and rf_read_addr==cpu_addr in the same cycle; all counters 0; a later start gives a clean full run.
- LANES=1 and LANES=4 builds, same image -> identical error_count; scan takes 33 and 9 cycles respectively; start pulsed during RUN has no effect.

Source files
------------

// File: rtl/regfile_scan_checker.sv
// End-of-run regfile self-check: counts a cycle budget while snooping writes, then hijacks the
// read ports and compares LANES registers per cycle against a synchronous expected-value ROM.
module regfile_scan_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int LANES          = 2,
  parameter int CYCLE_WIDTH    = 14,
  parameter int DEFAULT_CYCLES = 255,
  parameter int STOP_ON_FAIL   = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [CYCLE_WIDTH-1:0]           num_cycles,
  input  logic [LANES*ADDR_WIDTH-1:0]      cpu_addr,
  output logic [LANES*ADDR_WIDTH-1:0]      rf_read_addr,
  input  logic [LANES*DATA_WIDTH-1:0]      rf_read_data,
  output logic [ADDR_WIDTH-1:0]            exp_addr,
  input  logic [LANES*DATA_WIDTH-1:0]      exp_data,
  input  logic                             rwe,
  input  logic [4:0]                       rd,
  output logic                             test_mode,
  output logic [CYCLE_WIDTH-1:0]           cycle_count,
  output logic [15:0]                      write_count,
  output logic                             mismatch_valid,
  output logic [ADDR_WIDTH-1:0]            mismatch_reg,
  output logic [DATA_WIDTH-1:0]            mismatch_exp,
  output logic [DATA_WIDTH-1:0]            mismatch_act,
  output logic [ADDR_WIDTH:0]              error_count,
  output logic                             done,
  output logic                             pass
);

  localparam int NGROUPS = NUM_REGS / LANES;
  localparam logic [ADDR_WIDTH-1:0] LAST_GRP = ADDR_WIDTH'(NGROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_t;

  state_t                        state_q;
  logic [CYCLE_WIDTH-1:0]        budget_q;
  logic [CYCLE_WIDTH-1:0]        cycle_q;
  logic [15:0]                   wcnt_q;
  logic [ADDR_WIDTH:0]           ecnt_q;
  logic [ADDR_WIDTH-1:0]         grp_q;
  logic [ADDR_WIDTH-1:0]         cmp_grp_q;
  logic                          issue_q;
  logic                          cmp_vld_q;
  logic                          tm_q;
  logic                          done_q;
  logic [LANES*DATA_WIDTH-1:0]   act_q;
  logic                          mm_vld_q;
  logic [ADDR_WIDTH-1:0]         mm_reg_q;
  logic [DATA_WIDTH-1:0]         mm_exp_q;
  logic [DATA_WIDTH-1:0]         mm_act_q;

  logic [LANES-1:0]              lane_miss;
  logic [ADDR_WIDTH:0]           miss_cnt_d;
  logic [ADDR_WIDTH-1:0]         first_reg_d;
  logic [DATA_WIDTH-1:0]         first_exp_d;
  logic [DATA_WIDTH-1:0]         first_act_d;

  always_comb begin
    rf_read_addr = cpu_addr;
    for (int i = 0; i < LANES; i++) begin
      if (tm_q) rf_read_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(int'(grp_q) * LANES + i);
    end
  end

  // Descending walk so the lowest failing lane is the one left in first_*_d.
  always_comb begin
    lane_miss   = '0;
    miss_cnt_d  = '0;
    first_reg_d = '0;
    first_exp_d = '0;
    first_act_d = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      lane_miss[i] = cmp_vld_q && (exp_data[i*DATA_WIDTH +: DATA_WIDTH] != act_q[i*DATA_WIDTH +: DATA_WIDTH]);
      miss_cnt_d   = miss_cnt_d + {{ADDR_WIDTH{1'b0}}, lane_miss[i]};
      if (lane_miss[i]) begin
        first_reg_d = ADDR_WIDTH'(int'(cmp_grp_q) * LANES + i);
        first_exp_d = exp_data[i*DATA_WIDTH +: DATA_WIDTH];
        first_act_d = act_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      budget_q  <= '0;
      cycle_q   <= '0;
      wcnt_q    <= '0;
      ecnt_q    <= '0;
      grp_q     <= '0;
      cmp_grp_q <= '0;
      issue_q   <= 1'b0;
      cmp_vld_q <= 1'b0;
      tm_q      <= 1'b0;
      done_q    <= 1'b0;
      act_q     <= '0;
      mm_vld_q  <= 1'b0;
      mm_reg_q  <= '0;
      mm_exp_q  <= '0;
      mm_act_q  <= '0;
    end else begin
      mm_vld_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            budget_q <= (num_cycles == '0) ? CYCLE_WIDTH'(DEFAULT_CYCLES) : num_cycles;
            cycle_q  <= '0;
            wcnt_q   <= '0;
            ecnt_q   <= '0;
            done_q   <= 1'b0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          cycle_q <= cycle_q + CYCLE_WIDTH'(1);
          if (rwe && (rd != 5'd0) && (wcnt_q != 16'hFFFF)) wcnt_q <= wcnt_q + 16'd1;
          if (cycle_q == budget_q - CYCLE_WIDTH'(1)) begin
            state_q   <= S_SCAN;
            tm_q      <= 1'b1;
            grp_q     <= '0;
            issue_q   <= 1'b1;
            cmp_vld_q <= 1'b0;
          end
        end
        S_SCAN: begin
          // Read data is captured with the group it belongs to; the ROM supplies its half next cycle.
          act_q     <= rf_read_data;
          cmp_grp_q <= grp_q;
          cmp_vld_q <= issue_q;
          if (issue_q) begin
            if (grp_q == LAST_GRP) issue_q <= 1'b0;
            else                   grp_q   <= grp_q + ADDR_WIDTH'(1);
          end
          if (cmp_vld_q) begin
            ecnt_q <= ecnt_q + miss_cnt_d;
            if (lane_miss != '0) begin
              mm_vld_q <= 1'b1;
              mm_reg_q <= first_reg_d;
              mm_exp_q <= first_exp_d;
              mm_act_q <= first_act_d;
            end
            if (((STOP_ON_FAIL != 0) && (lane_miss != '0)) || (cmp_grp_q == LAST_GRP)) begin
              state_q   <= S_DONE;
              tm_q      <= 1'b0;
              done_q    <= 1'b1;
              issue_q   <= 1'b0;
              cmp_vld_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign exp_addr       = grp_q;
  assign test_mode      = tm_q;
  assign cycle_count    = cycle_q;
  assign write_count    = wcnt_q;
  assign mismatch_valid = mm_vld_q;
  assign mismatch_reg   = mm_reg_q;
  assign mismatch_exp   = mm_exp_q;
  assign mismatch_act   = mm_act_q;
  assign error_count    = ecnt_q;
  assign done           = done_q;
  assign pass           = done_q && (ecnt_q == '0);

endmodule

// File: tb/tb_regfile_scan_checker.sv
// Bench for regfile_scan_checker: four builds (default, stop-on-fail, 1 lane, 4 lanes) sharing
// one regfile/ROM image; mismatch pulses are scored against a queue filled from that image.
module tb_regfile_scan_checker;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] e;
    logic [31:0] a;
  } mm_t;

  logic        clock;
  logic        reset;
  logic [13:0] num_cycles;
  logic        rwe;
  logic [4:0]  wr_reg;
  logic [31:0] wr_val;

  logic [31:0] rf  [32] = '{default: 32'd0};
  logic [31:0] rom [32] = '{default: 32'd0};

  // default build
  logic st0, tm0, mv0, dn0, ps0;
  logic [9:0] ca0, ra0;
  logic [63:0] rdat0, ed0;
  logic [4:0] ea0, mr0;
  logic [13:0] cc0;
  logic [15:0] wc0;
  logic [31:0] me0, ma0;
  logic [5:0] ec0;
  // stop-on-fail build
  logic st1, tm1, mv1, dn1, ps1;
  logic [9:0] ca1, ra1;
  logic [63:0] rdat1, ed1;
  logic [4:0] ea1, mr1;
  logic [13:0] cc1;
  logic [15:0] wc1;
  logic [31:0] me1, ma1;
  logic [5:0] ec1;
  // one-lane build
  logic st2, tm2, mv2, dn2, ps2;
  logic [4:0] ca2, ra2;
  logic [31:0] rdat2, ed2;
  logic [4:0] ea2, mr2;
  logic [13:0] cc2;
  logic [15:0] wc2;
  logic [31:0] me2, ma2;
  logic [5:0] ec2;
  // four-lane build
  logic st3, tm3, mv3, dn3, ps3;
  logic [19:0] ca3, ra3;
  logic [127:0] rdat3, ed3;
  logic [4:0] ea3, mr3;
  logic [13:0] cc3;
  logic [15:0] wc3;
  logic [31:0] me3, ma3;
  logic [5:0] ec3;

  mm_t q0[$];
  mm_t q1[$];
  mm_t x0, x1;
  int n_cmp = 0;
  int n_bad = 0;

  regfile_scan_checker u_dut (
    .clock(clock), .reset(reset), .start(st0), .num_cycles(num_cycles), .cpu_addr(ca0),
    .rf_read_addr(ra0), .rf_read_data(rdat0), .exp_addr(ea0), .exp_data(ed0), .rwe(rwe), .rd(wr_reg),
    .test_mode(tm0), .cycle_count(cc0), .write_count(wc0), .mismatch_valid(mv0), .mismatch_reg(mr0),
    .mismatch_exp(me0), .mismatch_act(ma0), .error_count(ec0), .done(dn0), .pass(ps0));

  regfile_scan_checker #(.STOP_ON_FAIL(1)) u_sof (
    .clock(clock), .reset(reset), .start(st1), .num_cycles(num_cycles), .cpu_addr(ca1),
    .rf_read_addr(ra1), .rf_read_data(rdat1), .exp_addr(ea1), .exp_data(ed1), .rwe(rwe), .rd(wr_reg),
    .test_mode(tm1), .cycle_count(cc1), .write_count(wc1), .mismatch_valid(mv1), .mismatch_reg(mr1),
    .mismatch_exp(me1), .mismatch_act(ma1), .error_count(ec1), .done(dn1), .pass(ps1));

  regfile_scan_checker #(.LANES(1)) u_l1 (
    .clock(clock), .reset(reset), .start(st2), .num_cycles(num_cycles), .cpu_addr(ca2),
    .rf_read_addr(ra2), .rf_read_data(rdat2), .exp_addr(ea2), .exp_data(ed2), .rwe(rwe), .rd(wr_reg),
    .test_mode(tm2), .cycle_count(cc2), .write_count(wc2), .mismatch_valid(mv2), .mismatch_reg(mr2),
    .mismatch_exp(me2), .mismatch_act(ma2), .error_count(ec2), .done(dn2), .pass(ps2));

  regfile_scan_checker #(.LANES(4)) u_l4 (
    .clock(clock), .reset(reset), .start(st3), .num_cycles(num_cycles), .cpu_addr(ca3),
    .rf_read_addr(ra3), .rf_read_data(rdat3), .exp_addr(ea3), .exp_data(ed3), .rwe(rwe), .rd(wr_reg),
    .test_mode(tm3), .cycle_count(cc3), .write_count(wc3), .mismatch_valid(mv3), .mismatch_reg(mr3),
    .mismatch_exp(me3), .mismatch_act(ma3), .error_count(ec3), .done(dn3), .pass(ps3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Regfile model: r0 hardwired to zero, combinational reads.
  always @(posedge clock) if (rwe && wr_reg != 5'd0) rf[wr_reg] <= wr_val;

  always_comb begin
    rdat0 = '0; rdat1 = '0; rdat2 = '0; rdat3 = '0;
    for (int i = 0; i < 2; i++) begin
      rdat0[i*32 +: 32] = rf[ra0[i*5 +: 5]];
      rdat1[i*32 +: 32] = rf[ra1[i*5 +: 5]];
    end
    rdat2 = rf[ra2];
    for (int i = 0; i < 4; i++) rdat3[i*32 +: 32] = rf[ra3[i*5 +: 5]];
  end

  // Expected-value ROM: one-cycle read latency.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      ed0[i*32 +: 32] <= rom[(int'(ea0) * 2 + i) % 32];
      ed1[i*32 +: 32] <= rom[(int'(ea1) * 2 + i) % 32];
    end
    ed2 <= rom[ea2];
    for (int i = 0; i < 4; i++) ed3[i*32 +: 32] <= rom[(int'(ea3) * 4 + i) % 32];
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) if (mv0) begin
    chk_eq("mm0_pending", 64'(q0.size() > 0), 64'd1);
    if (q0.size() > 0) begin
      x0 = q0.pop_front();
      chk_eq("mm0_reg", 64'(mr0), 64'(x0.r));
      chk_eq("mm0_exp", 64'(me0), 64'(x0.e));
      chk_eq("mm0_act", 64'(ma0), 64'(x0.a));
    end
  end

  always @(negedge clock) if (mv1) begin
    chk_eq("mm1_pending", 64'(q1.size() > 0), 64'd1);
    if (q1.size() > 0) begin
      x1 = q1.pop_front();
      chk_eq("mm1_reg", 64'(mr1), 64'(x1.r));
      chk_eq("mm1_exp", 64'(me1), 64'(x1.e));
      chk_eq("mm1_act", 64'(ma1), 64'(x1.a));
    end
  end

  // Expected pulses for the 2-lane builds: lowest failing register of each failing group.
  task automatic push_exp(input int which);
    mm_t rec;
    for (int g = 0; g < 16; g++) begin
      bit found = 0;
      for (int l = 0; l < 2; l++) begin
        int r = g * 2 + l;
        if (!found && rf[r] != rom[r]) begin
          found = 1;
          rec.r = 5'(r); rec.e = rom[r]; rec.a = rf[r];
          if (which == 0) q0.push_back(rec); else q1.push_back(rec);
        end
      end
      if (found && which == 1) return;
    end
  endtask

  function automatic int model_errs(input bit stop);
    int n = 0;
    for (int g = 0; g < 16; g++) begin
      int gm = 0;
      for (int l = 0; l < 2; l++) if (rf[g*2+l] != rom[g*2+l]) gm++;
      n += gm;
      if (stop && gm > 0) return n;
    end
    return n;
  endfunction

  // Full run on the default build; CPU writes r3=7 in RUN cycle 2 and r0=5 in RUN cycle 4.
  task automatic run_main(input string tag, input int nc, input int exp_run);
    int k = 0;
    int s = 0;
    int ee;
    @(negedge clock); st0 = 1'b1; num_cycles = 14'(nc);
    @(negedge clock); st0 = 1'b0;
    chk_eq({tag, "_done_cleared"}, 64'(dn0), 64'd0);
    while (!tm0 && k < 2000) begin
      rwe    = (k == 2 || k == 4);
      wr_reg = (k == 2) ? 5'd3 : 5'd0;
      wr_val = (k == 2) ? 32'd7 : 32'd5;
      k++;
      @(negedge clock);
    end
    rwe = 1'b0;
    chk_eq({tag, "_run_cycles"}, 64'(k), 64'(exp_run));
    chk_eq({tag, "_cycle_count"}, 64'(cc0), 64'(exp_run));
    push_exp(0);
    ee = model_errs(0);
    while (tm0 && s < 200) begin
      s++;
      @(negedge clock);
    end
    chk_eq({tag, "_scan_cycles"}, 64'(s), 64'd17);
    chk_eq({tag, "_done"}, 64'(dn0), 64'd1);
    chk_eq({tag, "_write_count"}, 64'(wc0), 64'd1);
    chk_eq({tag, "_error_count"}, 64'(ec0), 64'(ee));
    chk_eq({tag, "_pass"}, 64'(ps0), 64'(ee == 0));
    repeat (3) @(negedge clock);
    chk_eq({tag, "_sb_drained"}, 64'(q0.size()), 64'd0);
  endtask

  initial begin
    int k, s;
    int r2, s2, r3c, s3;
    reset = 1'b0; num_cycles = '0; rwe = 1'b0; wr_reg = '0; wr_val = '0;
    st0 = 0; st1 = 0; st2 = 0; st3 = 0;
    ca0 = 10'h123; ca1 = '0; ca2 = '0; ca3 = '0;
    rom[3] = 32'd7;
    repeat (3) @(negedge clock);
    chk_eq("rst_test_mode", 64'(tm0), 64'd0);
    chk_eq("rst_done", 64'(dn0), 64'd0);
    chk_eq("rst_pass", 64'(ps0), 64'd0);
    chk_eq("rst_error_count", 64'(ec0), 64'd0);
    chk_eq("rst_cycle_count", 64'(cc0), 64'd0);
    chk_eq("rst_rf_addr_bypass", 64'(ra0), 64'h123);
    reset = 1'b1;

    run_main("t1", 10, 10);
    run_main("t2_default_budget", 0, 255);
    rom[4] = 32'd1; rom[5] = 32'd2;
    run_main("t3_group_miss", 3, 3);

    // Stop-on-fail build: failures at r6 (group 3) and r20 (group 10).
    rom[4] = '0; rom[5] = '0; rom[6] = 32'd9; rom[20] = 32'd3;
    @(negedge clock); st1 = 1'b1; num_cycles = 14'd5;
    @(negedge clock); st1 = 1'b0;
    k = 0;
    while (!tm1 && k < 100) begin k++; @(negedge clock); end
    chk_eq("sof_run_cycles", 64'(k), 64'd5);
    push_exp(1);
    s = 0;
    while (tm1 && s < 100) begin s++; @(negedge clock); end
    chk_eq("sof_scan_cycles", 64'(s), 64'd5);
    chk_eq("sof_done", 64'(dn1), 64'd1);
    chk_eq("sof_error_count", 64'(ec1), 64'(model_errs(1)));
    chk_eq("sof_pass", 64'(ps1), 64'd0);
    repeat (30) @(negedge clock);
    chk_eq("sof_sb_drained", 64'(q1.size()), 64'd0);
    chk_eq("sof_error_hold", 64'(ec1), 64'd1);

    // Reset dropped mid-scan on the default build at group 5.
    ca0 = 10'h2A5;
    @(negedge clock); st0 = 1'b1; num_cycles = 14'd4;
    @(negedge clock); st0 = 1'b0;
    k = 0;
    while (!tm0 && k < 100) begin k++; @(negedge clock); end
    push_exp(0);
    repeat (5) @(negedge clock);
    chk_eq("scan_exp_addr_g5", 64'(ea0), 64'd5);
    chk_eq("scan_lane0_addr_g5", 64'(ra0[4:0]), 64'd10);
    chk_eq("scan_lane1_addr_g5", 64'(ra0[9:5]), 64'd11);
    #2 reset = 1'b0;
    #1;
    chk_eq("midrst_test_mode", 64'(tm0), 64'd0);
    chk_eq("midrst_rf_addr", 64'(ra0), 64'h2A5);
    chk_eq("midrst_cycle_count", 64'(cc0), 64'd0);
    chk_eq("midrst_write_count", 64'(wc0), 64'd0);
    chk_eq("midrst_error_count", 64'(ec0), 64'd0);
    chk_eq("midrst_done", 64'(dn0), 64'd0);
    chk_eq("midrst_mm_valid", 64'(mv0), 64'd0);
    q0.delete();
    @(negedge clock); reset = 1'b1;
    run_main("t5_after_reset", 4, 4);

    // One- and four-lane builds on the same image; a start pulse during RUN must be ignored.
    r2 = 0; s2 = 0; r3c = 0; s3 = 0;
    @(negedge clock); st2 = 1'b1; st3 = 1'b1; num_cycles = 14'd4;
    @(negedge clock);
    for (int t = 0; t < 300 && !(dn2 && dn3); t++) begin
      st2 = (t == 2); st3 = (t == 2);
      if (tm2) s2++; else if (!dn2) r2++;
      if (tm3) s3++; else if (!dn3) r3c++;
      @(negedge clock);
    end
    st2 = 1'b0; st3 = 1'b0;
    chk_eq("l1_run_cycles", 64'(r2), 64'd4);
    chk_eq("l4_run_cycles", 64'(r3c), 64'd4);
    chk_eq("l1_scan_cycles", 64'(s2), 64'd33);
    chk_eq("l4_scan_cycles", 64'(s3), 64'd9);
    chk_eq("l1_done", 64'(dn2), 64'd1);
    chk_eq("l4_done", 64'(dn3), 64'd1);
    chk_eq("l1_error_count", 64'(ec2), 64'(model_errs(0)));
    chk_eq("l4_error_count", 64'(ec3), 64'(model_errs(0)));
    chk_eq("l1_l4_agree", 64'(ec3), 64'(ec2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
